// File: rtl/int_rsv_queue_pkg.sv
// Shared types for the integer reservation queue.
//   cdb_bfm    : one registered common-data-bus broadcast (valid, tag, data)
//   rs_opnd_t  : one source operand slot (ready flag, producer tag, value)
//   rs_entry_t : one reservation entry (busy, op, destination tag, two operands)
//   rs_wake    : CDB tag compare/capture for a single operand
package int_rsv_queue_pkg;

  localparam int unsigned RS_DEPTH   = 4;
  localparam int unsigned CDB_DATA_W = 32;
  localparam int unsigned CDB_TAG_W  = 6;
  localparam int unsigned RS_OP_W    = 4;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_bfm;

  typedef struct packed {
    logic                  rdy;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } rs_opnd_t;

  typedef struct packed {
    logic                 busy;
    logic [RS_OP_W-1:0]   op;
    logic [CDB_TAG_W-1:0] rd_tag;
    rs_opnd_t             rs1;
    rs_opnd_t             rs2;
  } rs_entry_t;

  // Ready operands never look at the bus, so a stale tag cannot overwrite a value.
  function automatic rs_opnd_t rs_wake(rs_opnd_t opnd, logic busy, cdb_bfm cdb);
    rs_opnd_t res;
    res = opnd;
    if (busy && !opnd.rdy && cdb.valid && (opnd.tag == cdb.tag)) begin
      res.rdy  = 1'b1;
      res.data = cdb.data;
    end
    return res;
  endfunction

endpackage

// File: rtl/int_rsv_queue_slot.sv
// rs_slot: one reservation entry register.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   clear_i        : synchronous clear (flush), wins over everything else
//   load_i         : write load_entry_i (dispatch)
//   shift_i        : take shift_entry_i (neighbour above moves down)
//   cdb_i          : CDB broadcast, applied to whichever source is selected
//   entry_o        : registered entry contents
module rs_slot
  import int_rsv_queue_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      clear_i,
  input  logic      load_i,
  input  logic      shift_i,
  input  rs_entry_t load_entry_i,
  input  rs_entry_t shift_entry_i,
  input  cdb_bfm    cdb_i,
  output rs_entry_t entry_o
);

  rs_entry_t entry_q, entry_d, src;

  always_comb begin
    src = entry_q;
    if (load_i) begin
      src = load_entry_i;
    end else if (shift_i) begin
      src = shift_entry_i;
    end
    // Wakeup after the mux: covers held, shifted and freshly dispatched (bypass) entries.
    entry_d     = src;
    entry_d.rs1 = rs_wake(src.rs1, src.busy, cdb_i);
    entry_d.rs2 = rs_wake(src.rs2, src.busy, cdb_i);
    if (clear_i) begin
      entry_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/int_rsv_queue.sv
// int_rsv_queue: age-ordered integer reservation queue (slot 0 = oldest).
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_flush          : synchronous clear of all entries
//   disp_*           : dispatch strobe and payload
//   cdb_in           : registered CDB broadcast used for operand wakeup
//   issue_int        : issue grant, removes the selected entry
//   full, ready_int  : queue status, from registered state only
//   ex_*             : payload of the oldest ready entry, zero when none
module int_rsv_queue
  import int_rsv_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = RS_DEPTH,
  parameter int unsigned DATA_W = CDB_DATA_W,
  parameter int unsigned TAG_W  = CDB_TAG_W,
  parameter int unsigned OP_W   = RS_OP_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              disp_en,
  input  logic [OP_W-1:0]   disp_op,
  input  logic [TAG_W-1:0]  disp_rd_tag,
  input  logic              disp_rs1_rdy,
  input  logic              disp_rs2_rdy,
  input  logic [TAG_W-1:0]  disp_rs1_tag,
  input  logic [TAG_W-1:0]  disp_rs2_tag,
  input  logic [DATA_W-1:0] disp_rs1_data,
  input  logic [DATA_W-1:0] disp_rs2_data,
  input  cdb_bfm            cdb_in,
  input  logic              issue_int,
  output logic              full,
  output logic              ready_int,
  output logic [OP_W-1:0]   ex_op,
  output logic [TAG_W-1:0]  ex_rd_tag,
  output logic [DATA_W-1:0] ex_rs1,
  output logic [DATA_W-1:0] ex_rs2
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  rs_entry_t slot_q   [DEPTH];
  rs_entry_t shift_in [DEPTH];
  rs_entry_t disp_entry, sel_entry;

  logic [DEPTH-1:0] load_vec, shift_vec;
  logic [IdxW-1:0]  sel_idx;
  logic [CntW-1:0]  count, load_idx;
  logic             found, do_issue, do_disp;

  always_comb begin
    disp_entry          = '0;
    disp_entry.busy     = 1'b1;
    disp_entry.op       = disp_op;
    disp_entry.rd_tag   = disp_rd_tag;
    disp_entry.rs1.rdy  = disp_rs1_rdy;
    disp_entry.rs1.tag  = disp_rs1_tag;
    disp_entry.rs1.data = disp_rs1_rdy ? disp_rs1_data : '0;
    disp_entry.rs2.rdy  = disp_rs2_rdy;
    disp_entry.rs2.tag  = disp_rs2_tag;
    disp_entry.rs2.data = disp_rs2_rdy ? disp_rs2_data : '0;
  end

  // Oldest ready entry and occupancy; busy entries are contiguous from slot 0.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    count   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_q[i].busy) begin
        count = count + CntW'(1);
      end
      if (!found && slot_q[i].busy && slot_q[i].rs1.rdy && slot_q[i].rs2.rdy) begin
        found   = 1'b1;
        sel_idx = IdxW'(i);
      end
    end
  end

  assign full      = slot_q[DEPTH-1].busy;
  assign ready_int = found;
  assign do_issue  = issue_int & found;
  assign do_disp   = disp_en & ~full;
  // First free slot after the same-cycle shift.
  assign load_idx  = do_issue ? count - CntW'(1) : count;

  always_comb begin
    load_vec  = '0;
    shift_vec = '0;
    for (int j = 0; j < DEPTH; j++) begin
      load_vec[j]  = do_disp && (CntW'(j) == load_idx);
      shift_vec[j] = do_issue && (IdxW'(j) >= sel_idx);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : gen_slot
    if (g == DEPTH - 1) begin : gen_top
      assign shift_in[g] = '0;
    end else begin : gen_mid
      assign shift_in[g] = slot_q[g+1];
    end

    rs_slot u_slot (
      .clk_i         (i_clk),
      .rst_ni        (i_rst_n),
      .clear_i       (i_flush),
      .load_i        (load_vec[g]),
      .shift_i       (shift_vec[g]),
      .load_entry_i  (disp_entry),
      .shift_entry_i (shift_in[g]),
      .cdb_i         (cdb_in),
      .entry_o       (slot_q[g])
    );
  end

  assign sel_entry = found ? slot_q[sel_idx] : '0;
  assign ex_op     = sel_entry.op;
  assign ex_rd_tag = sel_entry.rd_tag;
  assign ex_rs1    = sel_entry.rs1.data;
  assign ex_rs2    = sel_entry.rs2.data;

endmodule

// File: tb/tb_int_rsv_queue.sv
module tb_int_rsv_queue;
  import int_rsv_queue_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_flush;
  logic        disp_en;
  logic [3:0]  disp_op;
  logic [5:0]  disp_rd_tag;
  logic        disp_rs1_rdy, disp_rs2_rdy;
  logic [5:0]  disp_rs1_tag, disp_rs2_tag;
  logic [31:0] disp_rs1_data, disp_rs2_data;
  cdb_bfm      cdb_in;
  logic        issue_int;
  logic        full, ready_int;
  logic [3:0]  ex_op;
  logic [5:0]  ex_rd_tag;
  logic [31:0] ex_rs1, ex_rs2;

  typedef struct packed {
    logic [3:0]  op;
    logic [5:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  int_rsv_queue dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_flush       (i_flush),
    .disp_en       (disp_en),
    .disp_op       (disp_op),
    .disp_rd_tag   (disp_rd_tag),
    .disp_rs1_rdy  (disp_rs1_rdy),
    .disp_rs2_rdy  (disp_rs2_rdy),
    .disp_rs1_tag  (disp_rs1_tag),
    .disp_rs2_tag  (disp_rs2_tag),
    .disp_rs1_data (disp_rs1_data),
    .disp_rs2_data (disp_rs2_data),
    .cdb_in        (cdb_in),
    .issue_int     (issue_int),
    .full          (full),
    .ready_int     (ready_int),
    .ex_op         (ex_op),
    .ex_rd_tag     (ex_rd_tag),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted issue must match the oldest expectation.
  always @(negedge i_clk) begin
    if (i_rst_n && issue_int && ready_int) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL issue_unexpected: got rd_tag %0h expected no issue", ex_rd_tag);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("issue_payload", 64'({ex_op, ex_rd_tag, ex_rs1[15:0], ex_rs2[15:0]}),
            64'({e.op, e.rd, e.a[15:0], e.b[15:0]}));
        chk("issue_rs1_hi", 64'(ex_rs1), 64'(e.a));
        chk("issue_rs2_hi", 64'(ex_rs2), 64'(e.b));
      end
    end
  end

  task automatic idle();
    i_flush       = 1'b0;
    disp_en       = 1'b0;
    disp_op       = '0;
    disp_rd_tag   = '0;
    disp_rs1_rdy  = 1'b0;
    disp_rs2_rdy  = 1'b0;
    disp_rs1_tag  = '0;
    disp_rs2_tag  = '0;
    disp_rs1_data = '0;
    disp_rs2_data = '0;
    cdb_in        = '0;
    issue_int     = 1'b0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic disp(input logic [3:0] op, input logic [5:0] rd,
                      input logic r1, input logic [5:0] t1, input logic [31:0] d1,
                      input logic r2, input logic [5:0] t2, input logic [31:0] d2);
    disp_en       = 1'b1;
    disp_op       = op;
    disp_rd_tag   = rd;
    disp_rs1_rdy  = r1;
    disp_rs1_tag  = t1;
    disp_rs1_data = d1;
    disp_rs2_rdy  = r2;
    disp_rs2_tag  = t2;
    disp_rs2_data = d2;
  endtask

  task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
    cdb_in.valid = 1'b1;
    cdb_in.tag   = tag;
    cdb_in.data  = data;
  endtask

  task automatic issue(input logic [3:0] op, input logic [5:0] rd,
                       input logic [31:0] a, input logic [31:0] b);
    issue_int = 1'b1;
    sb.push_back('{op: op, rd: rd, a: a, b: b});
  endtask

  initial begin
    idle();
    i_rst_n = 1'b0;
    #12;
    chk("reset_full", 64'(full), 64'(0));
    chk("reset_ready", 64'(ready_int), 64'(0));
    chk("reset_ex", 64'({ex_op, ex_rd_tag, ex_rs1 | ex_rs2}), 64'(0));
    i_rst_n = 1'b1;
    tick();

    // Operand wakeup via CDB, then issue.
    disp(4'd1, 6'd10, 1'b1, 6'd0, 32'd5, 1'b0, 6'd7, 32'd0);
    tick();
    chk("wait_not_ready", 64'(ready_int), 64'(0));
    idle();
    cdb(6'd7, 32'd9);
    tick();
    chk("woken_ready", 64'(ready_int), 64'(1));
    idle();
    issue(4'd1, 6'd10, 32'd5, 32'd9);
    tick();
    chk("after_issue_empty", 64'(ready_int), 64'(0));
    idle();

    // Fill four entries; only the third is ready.
    disp(4'd2, 6'd20, 1'b0, 6'd30, 32'd0, 1'b1, 6'd0, 32'd1);
    tick();
    disp(4'd3, 6'd21, 1'b0, 6'd31, 32'd0, 1'b1, 6'd0, 32'd2);
    tick();
    disp(4'd4, 6'd22, 1'b1, 6'd0, 32'h11, 1'b1, 6'd0, 32'h22);
    tick();
    disp(4'd5, 6'd23, 1'b1, 6'd0, 32'd3, 1'b0, 6'd33, 32'd0);
    tick();
    chk("fill_full", 64'(full), 64'(1));
    chk("fill_sel_rd", 64'(ex_rd_tag), 64'(22));
    idle();
    // Dispatch while full is dropped even though an issue frees a slot.
    issue(4'd4, 6'd22, 32'h11, 32'h22);
    disp(4'd15, 6'd40, 1'b1, 6'd0, 32'hFF, 1'b1, 6'd0, 32'hFF);
    tick();
    chk("full_drops", 64'(full), 64'(0));
    chk("none_ready", 64'(ready_int), 64'(0));
    idle();
    cdb(6'd33, 32'h33);
    tick();
    chk("shifted_woken_rd", 64'(ex_rd_tag), 64'(23));
    idle();
    issue(4'd5, 6'd23, 32'd3, 32'h33);
    tick();
    idle();
    cdb(6'd30, 32'h30);
    tick();
    idle();
    issue(4'd2, 6'd20, 32'h30, 32'd1);
    tick();
    idle();
    cdb(6'd31, 32'h31);
    tick();
    idle();
    issue(4'd3, 6'd21, 32'h31, 32'd2);
    tick();
    idle();
    chk("drained_ready", 64'(ready_int), 64'(0));
    chk("drained_full", 64'(full), 64'(0));

    // Same-cycle dispatch bypass from the CDB.
    disp(4'd6, 6'd50, 1'b0, 6'd12, 32'd0, 1'b1, 6'd0, 32'h77);
    cdb(6'd12, 32'hABCD);
    tick();
    chk("bypass_ready", 64'(ready_int), 64'(1));
    chk("bypass_data", 64'(ex_rs1), 64'h0000ABCD);
    idle();
    issue(4'd6, 6'd50, 32'hABCD, 32'h77);
    tick();
    idle();

    // One broadcast wakes two entries; issue keeps age order.
    disp(4'd7, 6'd60, 1'b1, 6'd0, 32'd1, 1'b0, 6'd3, 32'd0);
    tick();
    disp(4'd8, 6'd61, 1'b1, 6'd0, 32'd2, 1'b0, 6'd3, 32'd0);
    tick();
    chk("two_waiting", 64'(ready_int), 64'(0));
    idle();
    cdb(6'd3, 32'h333);
    tick();
    chk("two_woken_first", 64'(ex_rd_tag), 64'(60));
    idle();
    issue(4'd7, 6'd60, 32'd1, 32'h333);
    tick();
    chk("two_woken_second", 64'(ex_rd_tag), 64'(61));
    idle();
    issue(4'd8, 6'd61, 32'd2, 32'h333);
    tick();
    idle();
    chk("two_drained", 64'(ready_int), 64'(0));

    // Flush overrides dispatch and issue.
    disp(4'd9, 6'd70, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1);
    tick();
    idle();
    i_flush = 1'b1;
    disp(4'd10, 6'd71, 1'b1, 6'd0, 32'd2, 1'b1, 6'd0, 32'd2);
    issue(4'd9, 6'd70, 32'd1, 32'd1);
    tick();
    idle();
    chk("flush_ready", 64'(ready_int), 64'(0));
    chk("flush_full", 64'(full), 64'(0));

    // Asynchronous reset with three busy entries.
    disp(4'd11, 6'd1, 1'b1, 6'd0, 32'd4, 1'b1, 6'd0, 32'd4);
    tick();
    disp(4'd12, 6'd2, 1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'd4);
    tick();
    disp(4'd13, 6'd3, 1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'd4);
    tick();
    idle();
    chk("pre_reset_ready", 64'(ready_int), 64'(1));
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("midreset_ready", 64'(ready_int), 64'(0));
    chk("midreset_full", 64'(full), 64'(0));
    chk("midreset_ex", 64'({ex_op, ex_rd_tag, ex_rs1 | ex_rs2}), 64'(0));
    tick();
    i_rst_n = 1'b1;
    tick();
    chk("post_reset_ready", 64'(ready_int), 64'(0));

    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_rsv_queue.md
# int_rsv_queue

Four-entry, age-ordered reservation queue in front of the integer execution unit. Holds dispatched integer ops until both source operands are available, and snoops the common data bus (CDB) every cycle to capture producer results by tag. Raises `ready_int` toward the issue unit, accepts `issue_int` back, and on issue drives the oldest ready op's operands to the integer unit. It is the consumer end of the issue handshake and of the CDB broadcast.

## Interface
- `DEPTH`, 4, number of entries (≥2)
- `DATA_W`, 32, operand/result width
- `TAG_W`, 6, producer tag width (matches `cdb_bfm` tag field)
- `OP_W`, 4, integer ALU op code width

- `i_clk` in 1: clock; single clock domain
- `i_rst_n` in 1: reset; asynchronous, active-low
- `i_flush` in 1: synchronous clear of all entries
- `disp_en` in 1: dispatch strobe
- `disp_op` in OP_W: ALU op
- `disp_rd_tag` in TAG_W: destination tag
- `disp_rs1_rdy`, `disp_rs2_rdy` in 1 each: operand already valid
- `disp_rs1_tag`, `disp_rs2_tag` in TAG_W: producer tag when not ready
- `disp_rs1_data`, `disp_rs2_data` in DATA_W: value when ready
- `cdb_in` in `cdb_bfm`: registered CDB broadcast (`valid`, `tag`, `data` fields)
- `issue_int` in 1: issue grant from issue unit
- `full` out 1: all DEPTH entries occupied
- `ready_int` out 1: at least one entry has both operands ready
- `ex_op` out OP_W, `ex_rd_tag` out TAG_W, `ex_rs1` out DATA_W, `ex_rs2` out DATA_W: payload of selected entry

## Operation
- Entry fields: `busy`, `op`, `rd_tag`, per operand {`rdy`, `tag`, `data`}. Entry 0 is oldest; busy entries always contiguous from index 0.
- Selection: lowest-index busy entry with `rs1.rdy & rs2.rdy`. `ready_int` = selection exists. `ex_*` show selected entry combinationally; all zero when none.
- Issue: `issue_int & ready_int` removes the selected entry at the clock edge; entries above shift down by one. `issue_int` with `ready_int`=0 is ignored.
- Dispatch: `disp_en & ~full` writes to the first free slot (after any same-cycle shift). `disp_en & full` is dropped, no state change, even if an issue happens that cycle.
- Wakeup: when `cdb_in.valid`, every busy not-ready operand whose tag equals `cdb_in.tag` sets `rdy` and captures `cdb_in.data`. Applied to shifting entries too (no wakeup lost on shift).
- Dispatch bypass: a dispatching not-ready operand whose tag matches a valid CDB that same cycle is written ready with CDB data.
- Both operands may wake on the same broadcast. Ready operands never compare tags.
- `i_flush`: all `busy` cleared next edge; overrides dispatch, issue and wakeup.

## Timing
- Reset (async): all `busy`/`rdy` = 0; `full`=0, `ready_int`=0, `ex_*`=0.
- `ready_int`, `full` derived from registered state only; no combinational path from `cdb_in` or `disp_*` to them.
- Entry woken by CDB in cycle N becomes eligible (`ready_int`) in N+1. Dispatched already-ready op eligible in N+1.
- Issue latency: 0 cycles, `ex_*` valid in the cycle `issue_int` is high; entry gone at N+1.
- Throughput: one dispatch and one issue per cycle.

## Structure
- `rs_entry_t` struct and `RS_DEPTH` default go in the shared package (`utils.sv`) next to `cdb_bfm`.
- One sub-module `rs_slot`: single entry register with load/shift-in/hold mux and CDB tag compare/capture; instantiated DEPTH times, priority selection and count in top.

## Test plan
- Reset mid-traffic with 3 busy entries -> all outputs 0 immediately, `full`=0.
- Dispatch op rs1 ready=5, rs2 waiting tag 7; CDB {valid, tag 7, data 9} next cycle -> `ready_int`=1 one cycle later, issue gives `ex_rs1`=5, `ex_rs2`=9.
- Fill 4 entries, entry 2 ready only -> issue removes entry 2, old entry 3 moves to slot 2, `full` drops; dispatch while full is dropped.
- Dispatch with rs1 tag 12 in the same cycle CDB broadcasts tag 12 data 0xABCD -> entry stored ready with 0xABCD.
- Entries 0 and 1 both waiting tag 3 on rs2 -> single CDB tag 3 wakes both; issues come out in order 0 then 1.
- `i_flush` together with `disp_en` and `issue_int` -> queue empty next cycle, no new entry.
